// File: rtl/pio_irq_servicer.sv
// Avalon-MM initiator that services an edge-capturing input PIO: programs its irq
// mask, reads capture/data on interrupt, clears the capture and streams one event record.
module pio_irq_servicer #(
  parameter int unsigned DATA_W    = 8,
  parameter logic [31:0] INIT_MASK = 32'h0000_00FF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [1:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              pio_irq,
  input  logic              mask_wr,
  input  logic [DATA_W-1:0] mask_in,
  output logic              event_valid,
  input  logic              event_ready,
  output logic [DATA_W-1:0] event_edges,
  output logic [DATA_W-1:0] event_data,
  output logic [CNT_W-1:0]  event_count,
  output logic              busy
);

  typedef enum logic [3:0] {
    S_INIT,
    S_INIT_WR,
    S_IDLE,
    S_MASK_WR,
    S_RD_CAP,
    S_RD_DAT,
    S_LATCH,
    S_CLEAR,
    S_OUT
  } state_t;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  state_t              state_q, state_d;
  logic [1:0]          addr_q, addr_d;
  logic                cs_q, cs_d;
  logic                wr_n_q, wr_n_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   edges_q, edges_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                busy_q, busy_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   mval_q, mval_d;
  logic                rd_unused;

  assign rd_unused = ^(avm_readdata >> DATA_W);

  always_comb begin
    state_d = state_q;
    edges_d = edges_q;
    data_d  = data_q;
    count_d = count_q;
    pend_d  = pend_q;
    mval_d  = mval_q;

    case (state_q)
      S_INIT:    state_d = S_INIT_WR;
      S_INIT_WR: state_d = S_IDLE;
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_MASK_WR;
          pend_d  = 1'b0;
        end else if (pio_irq) begin
          state_d = S_RD_CAP;
        end
      end
      S_MASK_WR: state_d = S_IDLE;
      S_RD_CAP:  state_d = S_RD_DAT;
      S_RD_DAT: begin
        edges_d = avm_readdata[DATA_W-1:0];
        state_d = S_LATCH;
      end
      S_LATCH: begin
        data_d  = avm_readdata[DATA_W-1:0];
        state_d = (edges_q == '0) ? S_IDLE : S_CLEAR;
      end
      S_CLEAR: state_d = S_OUT;
      S_OUT: begin
        if (event_ready) begin
          count_d = count_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase

    // A request arriving while the previous one is consumed stays pending.
    if (mask_wr) begin
      pend_d = 1'b1;
      mval_d = mask_in;
    end

    // Bus and stream outputs are registered for the state being entered, so they
    // line up with that state's cycle; readdata then arrives one state later.
    cs_d    = 1'b0;
    wr_n_d  = 1'b1;
    addr_d  = '0;
    wdata_d = '0;
    valid_d = 1'b0;
    case (state_d)
      S_INIT_WR: begin
        cs_d                 = 1'b1;
        wr_n_d               = 1'b0;
        addr_d               = ADDR_MASK;
        wdata_d[DATA_W-1:0]  = INIT_MASK[DATA_W-1:0];
      end
      S_MASK_WR: begin
        cs_d                 = 1'b1;
        wr_n_d               = 1'b0;
        addr_d               = ADDR_MASK;
        wdata_d[DATA_W-1:0]  = mval_q;
      end
      S_RD_CAP: begin
        cs_d   = 1'b1;
        addr_d = ADDR_CAP;
      end
      S_RD_DAT: begin
        cs_d   = 1'b1;
        addr_d = ADDR_DATA;
      end
      S_CLEAR: begin
        cs_d                 = 1'b1;
        wr_n_d               = 1'b0;
        addr_d               = ADDR_CAP;
        wdata_d[DATA_W-1:0]  = edges_q;
      end
      S_OUT:   valid_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      addr_q  <= '0;
      cs_q    <= 1'b0;
      wr_n_q  <= 1'b1;
      wdata_q <= '0;
      valid_q <= 1'b0;
      edges_q <= '0;
      data_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b1;
      pend_q  <= 1'b0;
      mval_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      wr_n_q  <= wr_n_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      edges_q <= edges_d;
      data_q  <= data_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      mval_q  <= mval_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wr_n_q;
  assign avm_writedata  = wdata_q;
  assign event_valid    = valid_q;
  assign event_edges    = edges_q;
  assign event_data     = data_q;
  assign event_count    = count_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Scoreboard bench for pio_irq_servicer: a behavioural PIO model answers the bus,
// expected bus cycles and event records are queued by stimulus and popped by monitors.
module tb_pio_irq_servicer;

  logic        clk;
  logic        reset;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        pio_irq;
  logic        mask_wr;
  logic [7:0]  mask_in;
  logic        event_valid;
  logic        event_ready;
  logic [7:0]  event_edges;
  logic [7:0]  event_data;
  logic [15:0] event_count;
  logic        busy;

  pio_irq_servicer #(
    .DATA_W    (8),
    .INIT_MASK (32'h0000_00FF),
    .CNT_W     (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .pio_irq        (pio_irq),
    .mask_wr        (mask_wr),
    .mask_in        (mask_in),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_edges    (event_edges),
    .event_data     (event_data),
    .event_count    (event_count),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PIO model: data/mask/capture registers, readdata one cycle after address.
  logic [7:0] pio_in;
  logic [7:0] cap_r;
  logic [7:0] mask_r;
  logic       force_irq;

  assign pio_irq = force_irq | (|(cap_r & mask_r));

  initial begin
    cap_r        = 8'h00;
    mask_r       = 8'h00;
    avm_readdata = 32'h0;
  end

  always @(posedge clk) begin
    case (avm_address)
      2'd0:    avm_readdata <= {24'h0, pio_in};
      2'd2:    avm_readdata <= {24'h0, mask_r};
      2'd3:    avm_readdata <= {24'h0, cap_r};
      default: avm_readdata <= 32'h0;
    endcase
    if (avm_chipselect && !avm_write_n) begin
      if (avm_address == 2'd2) mask_r <= avm_writedata[7:0];
      if (avm_address == 2'd3) cap_r  <= 8'h00;
    end
  end

  typedef struct {
    bit         wr;
    logic [1:0] addr;
    logic [31:0] data;
  } bus_t;

  typedef struct {
    logic [7:0]  edges;
    logic [7:0]  data;
    logic [15:0] count;
  } ev_t;

  bus_t busq[$];
  ev_t  evq[$];
  int   tests = 0;
  int   fails = 0;
  int   valid_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input bit wr, input logic [1:0] addr, input logic [31:0] data);
    bus_t b;
    b.wr = wr; b.addr = addr; b.data = data;
    busq.push_back(b);
  endtask

  task automatic exp_ev(input logic [7:0] e, input logic [7:0] d, input logic [15:0] c);
    ev_t v;
    v.edges = e; v.data = d; v.count = c;
    evq.push_back(v);
  endtask

  // Bus monitor: every chipselect cycle must match the next queued transaction.
  always @(negedge clk) begin
    if (avm_chipselect) begin
      if (busq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL bus_unexpected: got wr=%0d addr=%0d data=0x%0h, expected no access",
                 !avm_write_n, avm_address, avm_writedata);
      end else begin
        bus_t b;
        b = busq.pop_front();
        check("bus_wr", {31'h0, !avm_write_n}, {31'h0, b.wr});
        check("bus_addr", {30'h0, avm_address}, {30'h0, b.addr});
        if (b.wr) check("bus_wdata", avm_writedata, b.data);
      end
    end
  end

  // Event monitor: each accepted record is compared against the queue.
  always @(negedge clk) begin
    if (event_valid) valid_cycles++;
    if (event_valid && event_ready) begin
      if (evq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL ev_unexpected: got edges=0x%0h data=0x%0h, expected no event",
                 event_edges, event_data);
      end else begin
        ev_t v;
        v = evq.pop_front();
        check("ev_edges", {24'h0, event_edges}, {24'h0, v.edges});
        check("ev_data", {24'h0, event_data}, {24'h0, v.data});
        check("ev_count", {16'h0, event_count}, {16'h0, v.count});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    for (n = 0; n < 80; n++) begin
      if (evq.size() == 0 && busq.size() == 0 && !busy) break;
      tick();
    end
    check(name, {31'h0, n < 80}, 32'h1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!event_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    int n;
    int vc;
    reset       = 1'b1;
    force_irq   = 1'b0;
    mask_wr     = 1'b0;
    mask_in     = 8'h00;
    event_ready = 1'b0;
    pio_in      = 8'h00;

    // Reset state and the initial mask write.
    exp_bus(1'b1, 2'd2, 32'h0000_00FF);
    repeat (3) tick();
    check("rst_cs", {31'h0, avm_chipselect}, 32'h0);
    check("rst_write_n", {31'h0, avm_write_n}, 32'h1);
    check("rst_addr", {30'h0, avm_address}, 32'h0);
    check("rst_wdata", avm_writedata, 32'h0);
    check("rst_valid", {31'h0, event_valid}, 32'h0);
    check("rst_count", {16'h0, event_count}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h1);
    reset = 1'b0;
    tick();
    check("init_write_cycle", {30'h0, avm_chipselect, avm_write_n}, 32'h2);
    tick();
    check("init_idle_busy", {31'h0, busy}, 32'h0);
    check("init_idle_cs", {31'h0, avm_chipselect}, 32'h0);
    check("init_idle_valid", {31'h0, event_valid}, 32'h0);

    // Basic service with ready tied high; latency from irq sample to valid.
    event_ready = 1'b1;
    pio_in = 8'h04;
    exp_bus(1'b0, 2'd3, 32'h0);
    exp_bus(1'b0, 2'd0, 32'h0);
    exp_bus(1'b1, 2'd3, 32'h05);
    exp_ev(8'h05, 8'h04, 16'd0);
    cap_r = 8'h05;
    wait_valid(n);
    check("latency", n, 32'd5);
    wait_done("svc1_done");
    check("svc1_count", {16'h0, event_count}, 32'd1);

    // Consumer stall: record held stable, no bus traffic, count waits for accept.
    event_ready = 1'b0;
    pio_in = 8'hA5;
    exp_bus(1'b0, 2'd3, 32'h0);
    exp_bus(1'b0, 2'd0, 32'h0);
    exp_bus(1'b1, 2'd3, 32'h30);
    exp_ev(8'h30, 8'hA5, 16'd1);
    cap_r = 8'h30;
    wait_valid(n);
    check("stall_valid_seen", {31'h0, event_valid}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid", {31'h0, event_valid}, 32'h1);
      check("stall_edges", {24'h0, event_edges}, 32'h30);
      check("stall_data", {24'h0, event_data}, 32'hA5);
      check("stall_count", {16'h0, event_count}, 32'd1);
      check("stall_cs", {31'h0, avm_chipselect}, 32'h0);
    end
    event_ready = 1'b1;
    tick();
    check("stall_count_after", {16'h0, event_count}, 32'd2);
    check("stall_valid_after", {31'h0, event_valid}, 32'h0);
    wait_done("svc2_done");

    // Mask request during OUT with irq pending: mask write precedes next service.
    event_ready = 1'b0;
    pio_in = 8'h11;
    exp_bus(1'b0, 2'd3, 32'h0);
    exp_bus(1'b0, 2'd0, 32'h0);
    exp_bus(1'b1, 2'd3, 32'h01);
    exp_ev(8'h01, 8'h11, 16'd2);
    cap_r = 8'h01;
    wait_valid(n);
    check("mask_out_valid", {31'h0, event_valid}, 32'h1);
    exp_bus(1'b1, 2'd2, 32'h0F);
    exp_bus(1'b0, 2'd3, 32'h0);
    exp_bus(1'b0, 2'd0, 32'h0);
    exp_bus(1'b1, 2'd3, 32'h02);
    exp_ev(8'h02, 8'h11, 16'd3);
    mask_wr = 1'b1;
    mask_in = 8'h0F;
    cap_r = cap_r | 8'h02;
    tick();
    mask_wr = 1'b0;
    event_ready = 1'b1;
    wait_done("mask_done");
    check("mask_count", {16'h0, event_count}, 32'd4);

    // Spurious irq: capture reads zero, no clear write and no event.
    exp_bus(1'b0, 2'd3, 32'h0);
    exp_bus(1'b0, 2'd0, 32'h0);
    vc = valid_cycles;
    force_irq = 1'b1;
    tick();
    force_irq = 1'b0;
    repeat (10) tick();
    check("spur_no_valid", valid_cycles, vc);
    check("spur_count", {16'h0, event_count}, 32'd4);
    check("spur_idle", {31'h0, busy}, 32'h0);
    check("spur_bus_drained", busq.size(), 32'd0);

    // Reset during RD_DAT aborts the service; INIT write and re-service follow.
    exp_bus(1'b0, 2'd3, 32'h0);
    exp_bus(1'b0, 2'd0, 32'h0);
    exp_bus(1'b1, 2'd2, 32'h0000_00FF);
    exp_bus(1'b0, 2'd3, 32'h0);
    exp_bus(1'b0, 2'd0, 32'h0);
    exp_bus(1'b1, 2'd3, 32'h08);
    exp_ev(8'h08, 8'h00, 16'd0);
    pio_in = 8'h00;
    cap_r = 8'h08;
    tick();
    tick();
    check("rdat_addr", {29'h0, avm_chipselect, avm_address}, 32'h4);
    reset = 1'b1;
    tick();
    check("abort_cs", {31'h0, avm_chipselect}, 32'h0);
    check("abort_write_n", {31'h0, avm_write_n}, 32'h1);
    check("abort_data", {24'h0, event_data}, 32'h0);
    check("abort_count", {16'h0, event_count}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h1);
    reset = 1'b0;
    wait_done("abort_done");
    check("abort_final_count", {16'h0, event_count}, 32'd1);
    check("final_evq_empty", evq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pio_irq_servicer.md
Name: pio_irq_servicer

Overview:
- Avalon-MM initiator that services the 8-bit edge-capturing input PIO: programs the PIO's IRQ mask, waits for `irq`, reads the edge-capture and data registers, clears the capture, and emits one event record per interrupt on a valid/ready stream.
- Sits between the PIO and fabric logic that reacts to key/switch edges without the Nios II CPU in the loop.

Parameters:
- DATA_W, 8, width of PIO data, mask and capture fields (1..32).
- INIT_MASK, 8'hFF, value written to PIO register 2 (irq mask) after reset.
- CNT_W, 16, width of event_count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- avm_address  out  2  PIO register address (0 data, 2 irq mask, 3 edge capture).
- avm_chipselect  out  1  bus access strobe.
- avm_write_n  out  1  active-low write strobe.
- avm_writedata  out  32  write data, upper bits zero.
- avm_readdata  in  32  PIO read data; reflects the address presented one cycle earlier; no waitrequest.
- pio_irq  in  1  PIO interrupt, level.
- mask_wr  in  1  one-cycle request to reprogram the irq mask.
- mask_in  in  DATA_W  new mask value, sampled when mask_wr=1.
- event_valid  out  1  event record valid.
- event_ready  in  1  consumer accepts the record.
- event_edges  out  DATA_W  captured edge bits.
- event_data  out  DATA_W  PIO input level read after the capture.
- event_count  out  CNT_W  events accepted since reset, wrapping.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values: avm_address=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0, event_valid=0, event_edges=0, event_data=0, event_count=0, busy=1 (FSM in INIT).
- While reset is high, no write strobe is driven; reset mid-transaction aborts it and returns the FSM to INIT.
- INIT: one cycle with chipselect=1, write_n=0, address=2, writedata=INIT_MASK. Next state IDLE.
- IDLE: bus idle (chipselect=0, write_n=1).
  - If a mask request is pending, go to MASK_WR; a mask request has priority over pio_irq.
  - Else if pio_irq=1, go to RD_CAP.
- MASK_WR: one write cycle of the pending mask to address 2. Clear the pending flag, go to IDLE.
- mask_wr in any state latches mask_in into a pending register and sets the pending flag. A later mask_wr before service overwrites the value (last one wins).
- RD_CAP: chipselect=1, write_n=1, address=3.
- RD_DAT: address=0; capture avm_readdata[DATA_W-1:0] into an edges register.
- LATCH: bus idle; capture avm_readdata[DATA_W-1:0] into a data register.
- CLEAR: one write cycle, address=3, writedata=edges; the PIO clears all capture bits regardless of value.
- OUT: event_valid=1; event_edges and event_data hold stable until event_ready=1.
  - On the accept cycle (valid and ready both high): event_count increments (wraps at 2^CNT_W), event_valid drops next cycle, FSM goes to IDLE.
- Service latency: pio_irq sampled high in IDLE → event_valid high exactly 5 cycles later (RD_CAP, RD_DAT, LATCH, CLEAR, OUT entry).
- If LATCH reads edges==0 (spurious irq), skip CLEAR and OUT and return to IDLE; event_count is unchanged.
- Known loss window: an edge the PIO captures after the RD_CAP read is cleared by the CLEAR write and is not reported. Accepted by design.
- pio_irq is ignored outside IDLE. A level still high on return to IDLE starts a new service.
- event_ready while event_valid=0 has no effect.

Test Plan:
- Reset release with no stimulus → next cycle shows write to address 2 with writedata=0x000000FF; then bus idle, busy=0, event_valid=0.
- PIO model capture=0x05, data=0x04, irq asserted, event_ready tied 1 → reads of address 3 then 0, write to address 3, event_valid 5 cycles after irq with edges=0x05, data=0x04, event_count=1.
- Same as above with event_ready held 0 for 10 cycles → record stable for 10 cycles; no bus activity; count increments only on accept.
- mask_wr with mask_in=0x0F during OUT, pio_irq also high → after accept, write of 0x0F to address 2 occurs before the next RD_CAP.
- Irq asserted with capture reading 0x00 → no address-3 write, no event, event_count unchanged.
- Reset asserted during RD_DAT → outputs return to reset values next cycle; no write to address 3; INIT mask write follows release.
